// File: rtl/uart_txt_pkg.sv
// ---------------------------------------------------------------------------
// uart_txt_pkg: shared constants and state encoding for the uart2bus text protocol. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_txt_pkg;

  localparam logic [7:0] CH_W  = 8'h77;
  localparam logic [7:0] CH_R  = 8'h72;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_CR = 8'h0d;
  localparam logic [7:0] CH_LF = 8'h0a;

  localparam logic [3:0] WR_LEN = 4'd10;
  localparam logic [3:0] RD_LEN = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_RESP     = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/hex_ascii_codec.sv
// ---------------------------------------------------------------------------
// hex_ascii_codec: combinational nibble->ASCII encoder and ASCII->nibble decoder. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hex_ascii_codec #(
  parameter bit UPPER_HEX = 1'b0
) (
  input  logic [3:0] nib_i,
  output logic [7:0] asc_o,
  input  logic [7:0] asc_i,
  output logic       is_hex_o,
  output logic [3:0] nib_o
);

  // Offsets chosen so that nibble 10 lands on 'a' (0x61) or 'A' (0x41).
  always_comb begin
    if (nib_i < 4'd10) begin
      asc_o = 8'h30 + {4'h0, nib_i};
    end else begin
      asc_o = (UPPER_HEX ? 8'h37 : 8'h57) + {4'h0, nib_i};
    end
  end

  always_comb begin
    is_hex_o = 1'b0;
    nib_o    = 4'h0;
    if (asc_i >= 8'h30 && asc_i <= 8'h39) begin
      is_hex_o = 1'b1;
      nib_o    = asc_i[3:0];
    end else if ((asc_i >= 8'h61 && asc_i <= 8'h66) ||
                 (asc_i >= 8'h41 && asc_i <= 8'h46)) begin
      is_hex_o = 1'b1;
      nib_o    = asc_i[3:0] + 4'd9;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_txt_cmd_master.sv
// ---------------------------------------------------------------------------
// uart_txt_cmd_master: turns bus requests into uart2bus text commands and parses read replies. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_txt_cmd_master
  import uart_txt_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4000000,
  parameter bit UPPER_HEX      = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e        state_q, state_d;
  logic          wr_q, wr_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [3:0]    idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    acc_q, acc_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          bad_q, bad_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [3:0]    w_nib;
  logic          w_is_nib;
  logic [7:0]    w_lit;
  logic [7:0]    w_asc;
  logic          w_rx_hex;
  logic [3:0]    w_rx_nib;
  logic          w_last;

  hex_ascii_codec #(.UPPER_HEX(UPPER_HEX)) u_codec (
    .nib_i   (w_nib),
    .asc_o   (w_asc),
    .asc_i   (rx_data),
    .is_hex_o(w_rx_hex),
    .nib_o   (w_rx_nib)
  );

  // Byte at position idx: either a literal or a hex digit of wdata/addr, MSB first.
  always_comb begin
    w_nib    = 4'h0;
    w_is_nib = 1'b0;
    w_lit    = CH_SP;
    if (wr_q) begin
      case (idx_q)
        4'd0:    w_lit = CH_W;
        4'd2:    begin w_is_nib = 1'b1; w_nib = wdata_q[7:4];  end
        4'd3:    begin w_is_nib = 1'b1; w_nib = wdata_q[3:0];  end
        4'd5:    begin w_is_nib = 1'b1; w_nib = addr_q[15:12]; end
        4'd6:    begin w_is_nib = 1'b1; w_nib = addr_q[11:8];  end
        4'd7:    begin w_is_nib = 1'b1; w_nib = addr_q[7:4];   end
        4'd8:    begin w_is_nib = 1'b1; w_nib = addr_q[3:0];   end
        4'd9:    w_lit = CH_CR;
        default: w_lit = CH_SP;
      endcase
    end else begin
      case (idx_q)
        4'd0:    w_lit = CH_R;
        4'd2:    begin w_is_nib = 1'b1; w_nib = addr_q[15:12]; end
        4'd3:    begin w_is_nib = 1'b1; w_nib = addr_q[11:8];  end
        4'd4:    begin w_is_nib = 1'b1; w_nib = addr_q[7:4];   end
        4'd5:    begin w_is_nib = 1'b1; w_nib = addr_q[3:0];   end
        4'd6:    w_lit = CH_CR;
        default: w_lit = CH_SP;
      endcase
    end
  end

  assign tx_valid  = (state_q == ST_SEND);
  assign tx_data   = tx_valid ? (w_is_nib ? w_asc : w_lit) : 8'h00;
  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign w_last    = (idx_q == (wr_q ? WR_LEN - 4'd1 : RD_LEN - 4'd1));

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bad_d   = bad_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          idx_d   = 4'd0;
          acc_d   = 8'h00;
          cnt_d   = 2'd0;
          bad_d   = 1'b0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          if (w_last) begin
            timer_d = '0;
            if (wr_q) begin
              err_d   = 1'b0;
              state_d = ST_RESP;
            end else begin
              state_d = ST_WAIT_RSP;
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      ST_WAIT_RSP: begin
        timer_d = timer_q + TW'(1);
        // CR is checked first so it wins over a coincident timeout.
        if (rx_valid && rx_data == CH_CR) begin
          rdata_d = acc_q;
          err_d   = bad_q | (cnt_q == 2'd0);
          state_d = ST_RESP;
        end else begin
          if (rx_valid) begin
            if (w_rx_hex) begin
              acc_d = {acc_q[3:0], w_rx_nib};
              if (cnt_q != 2'd3) cnt_d = cnt_q + 2'd1;
            end else if (rx_data != CH_SP && rx_data != CH_LF) begin
              bad_d = 1'b1;
            end
          end
          if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
      idx_q   <= 4'd0;
      timer_q <= '0;
      acc_q   <= 8'h00;
      cnt_q   <= 2'd0;
      bad_q   <= 1'b0;
      rdata_q <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_txt_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_uart_txt_cmd_master: table-driven bench for the uart2bus text command master. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_txt_cmd_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = 16'h0;
  logic [7:0]  req_wdata = 8'h0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_valid = 1'b0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_txt_cmd_master #(.TIMEOUT_CYCLES(100), .UPPER_HEX(1'b0)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .busy     (busy)
  );

  // tx/rx strings are listed first byte in the most significant position.
  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [79:0] tx;
    logic [3:0]  ntx;
    logic [31:0] rx;
    logic [2:0]  nrx;
    logic [7:0]  rdata;
    logic        err;
    logic        chk_rd;
    logic        stall;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] got[10];
    int         n;
    int         cyc;
    int         nrsp;
    logic       stalled;
    logic [7:0] prev;
    logic [7:0] g_rd;
    logic       g_err;
    n = 0; cyc = 0; nrsp = 0; stalled = 1'b0; prev = 8'h00; g_rd = 8'h00; g_err = 1'b0;
    for (int i = 0; i < 10; i++) got[i] = 8'h00;

    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0; req_addr = 16'h0; req_wdata = 8'h0; req_write = 1'b0;
    chk("busy_send", {31'b0, busy}, 32'd1);

    while (n < int'(v.ntx) && cyc < 200) begin
      tx_ready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("tx_valid_send", {31'b0, tx_valid}, 32'd1);
      if (stalled) chk("tx_hold", {24'b0, tx_data}, {24'b0, prev});
      stalled = tx_valid && !tx_ready;
      prev    = tx_data;
      if (tx_valid && tx_ready) begin
        got[n] = tx_data;
        n++;
      end
      tick();
      cyc++;
    end
    tx_ready = 1'b0;
    chk("tx_count", n, 32'(v.ntx));
    for (int i = 0; i < int'(v.ntx); i++)
      chk("tx_byte", {24'b0, got[i]}, {24'b0, v.tx[79-8*i -: 8]});

    if (v.wr) begin
      chk("wr_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("wr_rsp_err", {31'b0, rsp_err}, 32'd0);
      chk("wr_tx_valid", {31'b0, tx_valid}, 32'd0);
      if (v.chk_rd) chk("wr_rdata_hold", {24'b0, rsp_rdata}, {24'b0, v.rdata});
      tick();
    end else if (v.nrx == 3'd0) begin
      cyc = 0;
      while (!rsp_valid && cyc < 300) begin
        tick();
        cyc++;
      end
      chk("timeout_cycles", cyc, 32'd100);
      chk("timeout_err", {31'b0, rsp_err}, 32'd1);
      if (v.chk_rd) chk("timeout_rdata", {24'b0, rsp_rdata}, {24'b0, v.rdata});
      tick();
    end else begin
      for (int i = 0; i < int'(v.nrx); i++) begin
        rx_valid = 1'b1;
        rx_data  = v.rx[31-8*i -: 8];
        tick();
        rx_valid = 1'b0;
        if (rsp_valid) begin
          nrsp++;
          g_rd  = rsp_rdata;
          g_err = rsp_err;
        end
      end
      chk("rd_rsp_count", nrsp, 32'd1);
      chk("rd_rsp_err", {31'b0, g_err}, {31'b0, v.err});
      if (v.chk_rd) chk("rd_rdata", {24'b0, g_rd}, {24'b0, v.rdata});
      if (rsp_valid) tick();
    end
    chk("rsp_pulse_end", {31'b0, rsp_valid}, 32'd0);
    chk("req_ready_back", {31'b0, req_ready}, 32'd1);
    chk("busy_back", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{wr:1'b1, addr:16'h0000, wdata:8'h01, tx:80'h77_20_30_31_20_30_30_30_30_0d, ntx:4'd10,
                rx:32'h0, nrx:3'd0, rdata:8'h00, err:1'b0, chk_rd:1'b0, stall:1'b0};
    vecs[1] = '{wr:1'b0, addr:16'h001a, wdata:8'h00, tx:80'h72_20_30_30_31_61_0d_00_00_00, ntx:4'd7,
                rx:32'h33_63_0d_0a, nrx:3'd4, rdata:8'h3c, err:1'b0, chk_rd:1'b1, stall:1'b0};
    vecs[2] = '{wr:1'b0, addr:16'habcd, wdata:8'h00, tx:80'h72_20_61_62_63_64_0d_00_00_00, ntx:4'd7,
                rx:32'h78_35_0d_00, nrx:3'd3, rdata:8'h00, err:1'b1, chk_rd:1'b0, stall:1'b0};
    vecs[3] = '{wr:1'b0, addr:16'hffff, wdata:8'h00, tx:80'h72_20_66_66_66_66_0d_00_00_00, ntx:4'd7,
                rx:32'h0d_00_00_00, nrx:3'd1, rdata:8'h00, err:1'b1, chk_rd:1'b0, stall:1'b0};
    vecs[4] = '{wr:1'b0, addr:16'h1234, wdata:8'h00, tx:80'h72_20_31_32_33_34_0d_00_00_00, ntx:4'd7,
                rx:32'h31_32_33_0d, nrx:3'd4, rdata:8'h23, err:1'b0, chk_rd:1'b1, stall:1'b0};
    vecs[5] = '{wr:1'b1, addr:16'hbeef, wdata:8'ha5, tx:80'h77_20_61_35_20_62_65_65_66_0d, ntx:4'd10,
                rx:32'h0, nrx:3'd0, rdata:8'h23, err:1'b0, chk_rd:1'b1, stall:1'b0};
    vecs[6] = '{wr:1'b0, addr:16'h5a3c, wdata:8'h00, tx:80'h72_20_35_61_33_63_0d_00_00_00, ntx:4'd7,
                rx:32'h41_0d_00_00, nrx:3'd2, rdata:8'h0a, err:1'b0, chk_rd:1'b1, stall:1'b1};
    vecs[7] = '{wr:1'b0, addr:16'h0000, wdata:8'h00, tx:80'h72_20_30_30_30_30_0d_00_00_00, ntx:4'd7,
                rx:32'h0, nrx:3'd0, rdata:8'h0a, err:1'b1, chk_rd:1'b1, stall:1'b0};

    rst = 1'b1;
    tick();
    tick();
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'b0, tx_data}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", {24'b0, rsp_rdata}, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reply bytes while idle must be ignored.
    rx_valid = 1'b1; rx_data = 8'h0d;
    tick();
    rx_valid = 1'b0;
    chk("idle_rx_ignored", {31'b0, rsp_valid}, 32'd0);
    chk("idle_rx_busy", {31'b0, busy}, 32'd0);

    // Reset in the middle of a write after four bytes have gone out.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h1234; req_wdata = 8'h56;
    tick();
    req_valid = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    tx_ready = 1'b0;
    chk("mid_tx_byte4", {24'b0, tx_data}, 32'h20);
    rst = 1'b1;
    tick();
    chk("mid_rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("mid_rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    rst = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rsp_valid || tx_valid) chk("post_rst_quiet", {30'b0, rsp_valid, tx_valid}, 32'd0);
    end
    tx_ready = 1'b0;
    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
